// File: rtl/surf_cin_pkg.sv
// Shared types and constants for the CIN command link receive path.
package surf_cin_pkg;

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        SLIP   = 3'd1,
        CHECK  = 3'd2,
        LOCKED = 3'd3
    } cin_rx_state_t;

    localparam logic [31:0] CIN_TRAIN_DEFAULT = 32'hA55A6996;
    localparam int          CIN_WORD_NIBBLES  = 8;

endpackage

// File: rtl/surf_cin_rx_aligner_asm.sv
// Nibble shift register and free-running word counter for the CIN receiver.
// boundary marks the cycle in which sr holds a complete word.
module cin_word_assembler
    import surf_cin_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  cin_raw_i,
    input  logic        wcnt_clr,
    output logic [31:0] sr,
    output logic        boundary
);

    logic [2:0] wcnt;

    // shift in one nibble per clock (bit 3 earliest); counter realigns on a hunt match
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sr   <= '0;
            wcnt <= '0;
        end else begin
            sr   <= {sr[27:0], cin_raw_i};
            wcnt <= wcnt_clr ? 3'd0 : wcnt + 3'd1;
        end
    end

    assign boundary = (wcnt == 3'(CIN_WORD_NIBBLES - 1));

endmodule

// File: rtl/surf_cin_rx_aligner.sv
// CIN receive aligner: hunts for the training word, drives ISERDES bitslip,
// confirms word alignment, then emits one command word per 8 clocks.
module surf_cin_rx_aligner
    import surf_cin_pkg::*;
#(
    parameter logic [31:0] TRAIN_SEQUENCE = CIN_TRAIN_DEFAULT,
    parameter int unsigned LOCK_COUNT     = 4,
    parameter int unsigned BITSLIP_WAIT   = 3
)(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  cin_raw_i,
    input  logic        relock_i,
    output logic        bitslip_o,
    output logic        locked_o,
    output logic        hunt_fail_o,
    output logic [31:0] command_o,
    output logic        command_valid_o,
    output logic [2:0]  state_o
);

    cin_rx_state_t state, state_nxt;
    logic [2:0]  hcnt, hcnt_nxt;
    logic [3:0]  scnt, scnt_nxt;
    logic [3:0]  mcnt, mcnt_nxt;
    logic [1:0]  slipcnt, slipcnt_nxt;
    logic        hunt_fail_nxt, bitslip_nxt, cmd_vld_nxt, cmd_load, wcnt_clr;
    logic [31:0] sr;
    logic        boundary, match;

    cin_word_assembler u_asm (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .cin_raw_i (cin_raw_i),
        .wcnt_clr  (wcnt_clr),
        .sr        (sr),
        .boundary  (boundary)
    );

    assign match   = (sr == TRAIN_SEQUENCE);
    assign state_o = state;

    // next-state and strobe decode; relock overrides everything else that cycle
    always_comb begin
        state_nxt     = state;
        hcnt_nxt      = 3'd0;
        scnt_nxt      = 4'd0;
        mcnt_nxt      = mcnt;
        slipcnt_nxt   = slipcnt;
        hunt_fail_nxt = hunt_fail_o;
        bitslip_nxt   = 1'b0;
        cmd_vld_nxt   = 1'b0;
        cmd_load      = 1'b0;
        wcnt_clr      = 1'b0;
        if (relock_i) begin
            state_nxt     = HUNT;
            mcnt_nxt      = 4'd0;
            slipcnt_nxt   = 2'd0;
            hunt_fail_nxt = 1'b0;
        end else begin
            unique case (state)
                HUNT: begin
                    if (match) begin
                        wcnt_clr  = 1'b1;
                        mcnt_nxt  = 4'd1;
                        state_nxt = CHECK;
                    end else if (hcnt == 3'(CIN_WORD_NIBBLES - 1)) begin
                        // every nibble rotation seen at this bit offset; try the next one
                        bitslip_nxt = 1'b1;
                        slipcnt_nxt = slipcnt + 2'd1;
                        if (slipcnt == 2'd3) hunt_fail_nxt = 1'b1;
                        state_nxt   = SLIP;
                    end else begin
                        hcnt_nxt = hcnt + 3'd1;
                    end
                end
                SLIP: begin
                    if (scnt == 4'(BITSLIP_WAIT - 1)) state_nxt = HUNT;
                    else                               scnt_nxt  = scnt + 4'd1;
                end
                CHECK: begin
                    if (boundary) begin
                        // a miss keeps the bit offset, so go back to hunting without slipping
                        if (!match) begin
                            mcnt_nxt  = 4'd0;
                            state_nxt = HUNT;
                        end else if (mcnt >= 4'(LOCK_COUNT)) begin
                            state_nxt = LOCKED;
                        end else begin
                            mcnt_nxt = mcnt + 4'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (boundary && !match) begin
                        cmd_load    = 1'b1;
                        cmd_vld_nxt = 1'b1;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // state, counters and registered outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state           <= HUNT;
            hcnt            <= '0;
            scnt            <= '0;
            mcnt            <= '0;
            slipcnt         <= '0;
            hunt_fail_o     <= 1'b0;
            bitslip_o       <= 1'b0;
            locked_o        <= 1'b0;
            command_o       <= '0;
            command_valid_o <= 1'b0;
        end else begin
            state           <= state_nxt;
            hcnt            <= hcnt_nxt;
            scnt            <= scnt_nxt;
            mcnt            <= mcnt_nxt;
            slipcnt         <= slipcnt_nxt;
            hunt_fail_o     <= hunt_fail_nxt;
            bitslip_o       <= bitslip_nxt;
            locked_o        <= (state == LOCKED) && !relock_i;
            command_valid_o <= cmd_vld_nxt;
            if (cmd_load) command_o <= sr;
        end
    end

endmodule

// File: tb/tb_surf_cin_rx_aligner.sv
// Bench for surf_cin_rx_aligner: a bit-serial TURFIO/ISERDES model feeds
// nibbles and honours bitslip; commands are scored through an expect queue.
module tb_surf_cin_rx_aligner;

    localparam logic [31:0] TRAIN = 32'hA55A6996;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  cin_raw_i = 4'd0;
    logic        relock_i = 1'b0;
    logic        bitslip_o, locked_o, hunt_fail_o, command_valid_o;
    logic [31:0] command_o;
    logic [2:0]  state_o;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        bq[$];
    logic [31:0] fill_word = TRAIN;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int          slip_cyc[$];
    int          strobe_cyc[$];
    int          m1, lk;

    always #5 aclk = ~aclk;

    surf_cin_rx_aligner dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .cin_raw_i       (cin_raw_i),
        .relock_i        (relock_i),
        .bitslip_o       (bitslip_o),
        .locked_o        (locked_o),
        .hunt_fail_o     (hunt_fail_o),
        .command_o       (command_o),
        .command_valid_o (command_valid_o),
        .state_o         (state_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) bq.push_back(w[i]);
    endtask

    task automatic drive_nib();
        logic [3:0] nib;
        if (bq.size() < 4) push_bits(fill_word, 32);
        for (int i = 3; i >= 0; i--) nib[i] = bq.pop_front();
        cin_raw_i = nib;
    endtask

    // one clock; a bitslip drops one bit from the serial stream
    task automatic step();
        @(posedge aclk);
        #1;
        cyc++;
        if (aresetn && bitslip_o) begin
            slip_cyc.push_back(cyc);
            if (bq.size() == 0) push_bits(fill_word, 32);
            void'(bq.pop_front());
        end
        drive_nib();
    endtask

    task automatic reset_dut();
        aresetn  = 1'b0;
        relock_i = 1'b0;
        cin_raw_i = 4'd0;
        repeat (3) @(posedge aclk);
        #1;
        bq.delete();
        slip_cyc.delete();
        strobe_cyc.delete();
    endtask

    task automatic release_rst();
        aresetn = 1'b1;
        cyc = 0;
        drive_nib();
    endtask

    task automatic wait_locked(input int budget, input string name);
        int n = 0;
        while (locked_o !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(name, locked_o, 1'b1);
    endtask

    // scoreboard monitor: every strobe must match the next expected word
    always @(negedge aclk) begin
        if (aresetn && command_valid_o) begin
            strobe_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got command %h, want no strobe (cycle %0d)", command_o, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (command_o !== mon_exp) begin
                    errors++;
                    $display("FAIL command: got %h want %h (cycle %0d)", command_o, mon_exp, cyc);
                end
            end
            checks++;
            if (state_o !== 3'd3) begin
                errors++;
                $display("FAIL strobe_state: got %0d want 3", state_o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        reset_dut();
        chk("rst_state", state_o, 3'd0);
        chk("rst_bitslip", bitslip_o, 1'b0);
        chk("rst_locked", locked_o, 1'b0);
        chk("rst_hunt_fail", hunt_fail_o, 1'b0);
        chk("rst_command", command_o, 32'h0);
        chk("rst_valid", command_valid_o, 1'b0);

        // aligned training, nibble offset 3; relock held while sr fills
        fill_word = TRAIN;
        push_bits(TRAIN, 20);
        relock_i = 1'b1;
        release_rst();
        while (cyc < 9) step();
        step();
        relock_i = 1'b0;
        while (cyc < 13) step();
        chk("t1_hunt_c13", state_o, 3'd0);
        step();
        chk("t1_check_c14", state_o, 3'd2);
        while (cyc < 45) step();
        chk("t1_check_c45", state_o, 3'd2);
        step();
        chk("t1_locked_state_c46", state_o, 3'd3);
        chk("t1_locked_o_c46", locked_o, 1'b0);
        step();
        chk("t1_locked_o_c47", locked_o, 1'b1);
        chk("t1_no_slip", slip_cyc.size(), 0);
        chk("t1_hunt_fail", hunt_fail_o, 1'b0);

        // locked commands; the embedded training word is suppressed
        push_bits(32'h12345678, 32);
        push_bits(TRAIN, 32);
        push_bits(32'hDEADBEEF, 32);
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'hDEADBEEF);
        while (cyc < 90) step();
        chk("t4_strobe_count", strobe_cyc.size(), 2);
        chk("t4_first_strobe_cyc", (strobe_cyc.size() > 0) ? strobe_cyc[0] : -1, 62);
        chk("t4_strobe_gap", (strobe_cyc.size() > 1) ? strobe_cyc[1] - strobe_cyc[0] : -1, 16);
        chk("t4_exp_drained", exp_q.size(), 0);
        chk("t4_cmd_hold", command_o, 32'hDEADBEEF);

        // corrupted word in CHECK at mcnt=2 -> back to HUNT, no slip
        relock_i = 1'b1;
        step();
        relock_i = 1'b0;
        chk("t5_relock_state", state_o, 3'd0);
        chk("t5_relock_locked", locked_o, 1'b0);
        begin
            int n = 0;
            while (state_o !== 3'd2 && n < 16) begin step(); n++; end
        end
        chk("t5_enter_check", state_o, 3'd2);
        m1 = cyc;
        push_bits(32'hA55A6997, 32);
        while (cyc < m1 + 15) step();
        chk("t5_still_check", state_o, 3'd2);
        step();
        chk("t5_back_to_hunt", state_o, 3'd0);
        while (cyc < m1 + 24) step();
        chk("t5_recheck", state_o, 3'd2);
        wait_locked(40, "t5_relocked");
        chk("t5_no_slip", slip_cyc.size(), 0);

        // relock on a LOCKED boundary carrying a command word
        lk = cyc;
        push_bits(32'hCAFEF00D, 32);
        while (cyc < lk + 14) step();
        relock_i = 1'b1;
        step();
        relock_i = 1'b0;
        chk("t6_state", state_o, 3'd0);
        chk("t6_valid", command_valid_o, 1'b0);
        chk("t6_locked", locked_o, 1'b0);
        chk("t6_cmd_hold", command_o, 32'hDEADBEEF);
        repeat (10) step();

        // stream skewed by 2 bits -> two slips, then lock
        reset_dut();
        fill_word = TRAIN;
        push_bits(TRAIN, 14);
        release_rst();
        wait_locked(80, "t2_locked");
        chk("t2_lock_cyc", cyc, 61);
        chk("t2_slip_count", slip_cyc.size(), 2);
        chk("t2_slip0_cyc", (slip_cyc.size() > 0) ? slip_cyc[0] : -1, 8);
        chk("t2_slip1_cyc", (slip_cyc.size() > 1) ? slip_cyc[1] : -1, 19);
        chk("t2_hunt_fail", hunt_fail_o, 1'b0);

        // constant zero -> slip every 11 cycles, hunt_fail on the 4th
        reset_dut();
        fill_word = 32'h0;
        release_rst();
        while (cyc < 40) step();
        chk("t3_fail_c40", hunt_fail_o, 1'b0);
        step();
        chk("t3_fail_c41", hunt_fail_o, 1'b1);
        chk("t3_bitslip_c41", bitslip_o, 1'b1);
        chk("t3_slip_count", slip_cyc.size(), 4);
        chk("t3_slip0_cyc", (slip_cyc.size() > 0) ? slip_cyc[0] : -1, 8);
        chk("t3_slip2_cyc", (slip_cyc.size() > 2) ? slip_cyc[2] : -1, 30);
        relock_i = 1'b1;
        step();
        relock_i = 1'b0;
        chk("t3_relock_clears_fail", hunt_fail_o, 1'b0);
        chk("t3_relock_state", state_o, 3'd0);
        begin
            int n = 0;
            while (bitslip_o !== 1'b1 && n < 12) begin step(); n++; end
        end
        chk("t3_next_slip_cyc", cyc, 50);
        chk("t3_in_slip", state_o, 3'd1);

        // async reset mid-SLIP
        aresetn = 1'b0;
        #1;
        chk("t7_bitslip", bitslip_o, 1'b0);
        chk("t7_state", state_o, 3'd0);
        chk("t7_locked", locked_o, 1'b0);
        chk("t7_hunt_fail", hunt_fail_o, 1'b0);
        chk("t7_command", command_o, 32'h0);
        chk("t7_valid", command_valid_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
